axi_wr_queue: RTL and testbench
===============================

// Module: axi_wr_queue
// PURPOSE
//  Parametrised write-back queue and AXI write master for the dcache path. It buffers up to
//  DEPTH pending writes (full lines or single words) and drains them in order over AW/W/B.
//  It exposes a same-line hazard lookup, so the read arbiter stalls only on a conflicting line
//  instead of on any pending write. Sits between dcache write port and the AXI interconnect.
// PARAMETERS
//  DEPTH       4   queue entries; power of two, >=2; all DEPTH slots usable
//  LINE_WORDS  4   32-bit words per cache line; power of two, >=2; LINE_WIDTH=32*LINE_WORDS
//  AXI_ID      1   4-bit ID driven on awid/wid and required on bid
// PORTS
//  clk        in   1           clock
//  reset      in   1           synchronous, active-high reset
//  wr_req     in   1           enqueue request
//  wr_type    in   3           3'b000/001/010 = byte/half/word (awsize); 3'b100 = full line
//  wr_addr    in   32          write address (line types: line-aligned)
//  wr_wstrb   in   4           byte strobes for non-line types
//  wr_data    in   LINE_WIDTH  line data, word 0 in [31:0]; non-line types use [31:0]
//  wr_rdy     out  1           queue can accept this cycle
//  chk_addr   in   32          read address to check for hazard
//  chk_hit    out  1           a pending write targets chk_addr's line
//  empty      out  1           no entries and no transaction in flight
//  wr_err     out  1           sticky: a B response had bresp!=0
//  awid/awaddr/awlen/awsize/awburst  out 4/32/8/3/2  AW payload
//  awvalid    out  1 ; awready in 1
//  wid/wdata/wstrb/wlast  out 4/32/4/1  W payload
//  wvalid     out  1 ; wready in 1
//  bid/bresp  in   4/2 ; bvalid in 1 ; bready out 1
// BEHAVIOUR
//  Reset: head=tail=count=0, FSM=IDLE, beat=0, wr_err=0. While reset is high: wr_rdy=0,
//   awvalid=wvalid=wlast=bready=0, empty=1, chk_hit=0. Reset mid-burst abandons the burst
//   and discards all entries.
//  Push: wr_req&wr_rdy writes slot[tail]; tail++ (mod DEPTH); count++. wr_rdy = count<DEPTH.
//   Push and pop in the same cycle are both applied (count unchanged). A pushed entry can
//   drive AW no earlier than the next cycle.
//  Entry fields: line=(type==3'b100); awlen=line?LINE_WORDS-1:0; awsize=line?3'b010:type;
//   awburst=2'b01 (INCR); strobe=line?4'hf:wr_wstrb.
//  FSM (one transaction at a time, in order):
//   IDLE: count!=0 -> AW; beat<=0.
//   AW: awvalid=1, payload from slot[head]; awready -> W.
//   W: wvalid=1; wdata=slot[head] word[beat]; wstrb=entry strobe; wlast=(beat==awlen).
//    On wready: if wlast -> B; else beat++.
//   B: bready=1; bvalid&(bid==AXI_ID) -> pop (head++, count--), IDLE; bresp!=0 sets wr_err.
//   B responses with another bid are not consumed. Best case per single-word entry:
//   4 cycles IDLE->AW->W->B->IDLE, with AW/W/B each ready on first cycle.
//  chk_hit = OR over occupied slots (including head until its B is accepted) of
//   addr[31:OFF]==chk_addr[31:OFF], OFF=log2(LINE_WORDS)+2. The same-cycle accepted push
//   (wr_req&wr_rdy) is also compared. Purely combinational.
//  empty = (count==0)&(FSM==IDLE). Payloads hold stable while valid and not ready.
//  Wrap-around: head/tail are log2(DEPTH) bits wide and wrap naturally. count is
//   log2(DEPTH)+1 bits wide and distinguishes full from empty.
// TESTING
//  1. Push word 0x1000 data 0xdeadbeef strb 4'h3, all ready=1 -> awaddr=0x1000, awlen=0,
//     awsize=2, single beat wlast=1 wstrb=3, bready then empty=1 after 4 cycles.
//  2. Push line 0x2000 with words 0..3=0x11,0x22,0x33,0x44, wready toggling -> 4 beats in
//     order, wlast only on 0x44, awlen=3, wstrb=4'hf.
//  3. Push DEPTH entries with awready=0 -> wr_rdy=0 after 4th; release -> in-order drain;
//     push during the pop cycle is accepted; tail wraps to 0.
//  4. Pending line 0x3000: chk_addr=0x300c -> chk_hit=1; chk_addr=0x3010 -> 0; hit drops the
//     cycle after its B handshake; same-cycle push of 0x4000 with chk_addr=0x4004 -> hit=1.
//  5. bresp=2'b10 on first B -> wr_err=1 and stays 1 through later OKAY responses until reset.
//  6. Assert reset during beat 2 of a line burst -> next cycle wvalid=0, empty=1, wr_rdy=1
//     after reset drops, no further AW for the discarded entries.

Source files
------------

// File: rtl/axi_wr_queue_if.sv
// AXI write-channel bundle (AW/W/B) between the write queue and the interconnect.
//  master: drives AW/W payload and valids, bready; samples awready/wready/B response.
//  slave : the opposite direction (interconnect or bench side).
interface axi_wr_queue_if;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wid, wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wid, wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_wr_queue.sv
// Write-back queue + AXI write master for the dcache path.
// Buffers up to DEPTH writes (full lines or single words) and drains them in
// order, one AW/W/B transaction at a time. chk_hit flags a pending write to the
// same cache line as chk_addr so reads stall only on a real conflict.
// Ports:
//  clk, reset           clock, synchronous active-high reset
//  wr_req/wr_type/wr_addr/wr_wstrb/wr_data, wr_rdy   enqueue side
//  chk_addr, chk_hit    same-line hazard lookup (combinational)
//  empty                no entries queued and FSM idle
//  wr_err               sticky error from any non-OKAY bresp
//  axi                  AXI write channels (master modport)
module axi_wr_queue #(
  parameter int         DEPTH      = 4,
  parameter int         LINE_WORDS = 4,
  parameter logic [3:0] AXI_ID     = 4'd1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_req,
  input  logic [2:0]                wr_type,
  input  logic [31:0]               wr_addr,
  input  logic [3:0]                wr_wstrb,
  input  logic [32*LINE_WORDS-1:0]  wr_data,
  output logic                      wr_rdy,
  input  logic [31:0]               chk_addr,
  output logic                      chk_hit,
  output logic                      empty,
  output logic                      wr_err,
  axi_wr_queue_if.master            axi
);
  localparam int PW  = $clog2(DEPTH);
  localparam int BW  = $clog2(LINE_WORDS);
  localparam int OFF = BW + 2;

  typedef struct packed {
    logic [31:0]                  addr;
    logic                         line;
    logic [2:0]                   size;
    logic [3:0]                   strb;
    logic [LINE_WORDS-1:0][31:0]  data;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PW:0]     count_q, count_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            err_q, err_d;
  entry_t          slot_q [DEPTH];
  entry_t          slot_d;
  entry_t          hd;
  logic            push, pop, last_beat;
  logic [7:0]      hd_len;

  // Low line-offset bits never take part in the hazard compare.
  logic unused_ok;
  assign unused_ok = ^chk_addr[OFF-1:0];

  assign hd        = slot_q[head_q];
  assign hd_len    = hd.line ? 8'(LINE_WORDS - 1) : 8'd0;
  assign last_beat = ({{(8-BW){1'b0}}, beat_q} == hd_len);
  assign wr_rdy    = ~reset & (count_q < (PW+1)'(DEPTH));
  assign push      = wr_req & wr_rdy;
  // Only a response carrying our ID retires the head entry.
  assign pop       = ~reset & (state_q == S_B) & axi.bvalid & (axi.bid == AXI_ID);

  // Entry built from the request bus.
  always_comb begin
    slot_d      = '0;
    slot_d.addr = wr_addr;
    slot_d.line = (wr_type == 3'b100);
    slot_d.size = slot_d.line ? 3'b010 : wr_type;
    slot_d.strb = slot_d.line ? 4'hf : wr_wstrb;
    slot_d.data = wr_data;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by head/count.
  always_ff @(posedge clk) begin
    if (push) slot_q[tail_q] <= slot_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(push);
    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
    err_d   = err_q | (pop & (axi.bresp != 2'b00));
    case (state_q)
      S_IDLE: if (count_q != '0) begin
        state_d = S_AW;
        beat_d  = '0;
      end
      S_AW: if (axi.awready) state_d = S_W;
      S_W: if (axi.wready) begin
        if (last_beat) state_d = S_B;
        else           beat_d  = beat_q + 1'b1;
      end
      S_B: if (pop) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs; handshakes are masked while reset is held so nothing escapes
  // from an abandoned burst.
  always_comb begin
    axi.awid    = AXI_ID;
    axi.awaddr  = hd.addr;
    axi.awlen   = hd_len;
    axi.awsize  = hd.size;
    axi.awburst = 2'b01;
    axi.wid     = AXI_ID;
    axi.wdata   = hd.data[beat_q];
    axi.wstrb   = hd.strb;
    axi.awvalid = ~reset & (state_q == S_AW);
    axi.wvalid  = ~reset & (state_q == S_W);
    axi.wlast   = ~reset & (state_q == S_W) & last_beat;
    axi.bready  = ~reset & (state_q == S_B);
    empty       = reset | ((count_q == '0) & (state_q == S_IDLE));
    wr_err      = ~reset & err_q;
  end

  // Hazard lookup: occupied slots are the count_q entries starting at head.
  always_comb begin
    logic [PW-1:0] off;
    off     = '0;
    chk_hit = push & (wr_addr[31:OFF] == chk_addr[31:OFF]);
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head_q;
      if (({1'b0, off} < count_q) && (slot_q[i].addr[31:OFF] == chk_addr[31:OFF]))
        chk_hit = 1'b1;
    end
    if (reset) chk_hit = 1'b0;
  end
endmodule

// File: tb/tb_axi_wr_queue.sv
module tb_axi_wr_queue;
  logic         clk = 1'b0;
  logic         reset;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;
  logic [31:0]  chk_addr;
  logic         chk_hit;
  logic         empty;
  logic         wr_err;
  int           checks = 0;
  int           errors = 0;

  axi_wr_queue_if axi();

  axi_wr_queue #(.DEPTH(4), .LINE_WORDS(4), .AXI_ID(4'd1)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_type(wr_type),
    .wr_addr(wr_addr), .wr_wstrb(wr_wstrb), .wr_data(wr_data),
    .wr_rdy(wr_rdy), .chk_addr(chk_addr), .chk_hit(chk_hit),
    .empty(empty), .wr_err(wr_err), .axi(axi)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for AW, check its address, then step past the handshake.
  task automatic wait_aw(input string tag, input logic [31:0] addr);
    for (int n = 0; n < 40 && !axi.awvalid; n++) tick();
    chk({tag, "_awvalid"}, axi.awvalid, 1);
    chk({tag, "_awaddr"}, axi.awaddr, addr);
    tick();
  endtask

  task automatic wait_b(input string tag);
    for (int n = 0; n < 40 && !axi.bready; n++) tick();
    chk({tag, "_bready"}, axi.bready, 1);
  endtask

  task automatic wait_empty(input string tag);
    for (int n = 0; n < 60 && !empty; n++) tick();
    chk({tag, "_empty"}, empty, 1);
  endtask

  task automatic push_word(input logic [31:0] a, input logic [31:0] d);
    wr_req = 1; wr_type = 3'b010; wr_addr = a; wr_wstrb = 4'hf; wr_data = {96'd0, d};
  endtask

  initial begin
    logic [127:0] line2;
    reset = 1; wr_req = 0; wr_type = 0; wr_addr = 0; wr_wstrb = 0; wr_data = 0;
    chk_addr = 0;
    axi.awready = 1; axi.wready = 1; axi.bvalid = 1; axi.bid = 4'd1; axi.bresp = 2'b00;
    tick(); tick();
    chk("rst_wr_rdy", wr_rdy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_wvalid", axi.wvalid, 0);
    chk("rst_bready", axi.bready, 0);
    chk("rst_wr_err", wr_err, 0);
    reset = 0;
    #1;
    chk("post_rst_wr_rdy", wr_rdy, 1);
    chk("post_rst_empty", empty, 1);

    // 1: single word, everything ready
    wr_req = 1; wr_type = 3'b010; wr_addr = 32'h1000; wr_wstrb = 4'h3;
    wr_data = {96'd0, 32'hdeadbeef}; chk_addr = 32'h1000;
    #1;
    chk("t1_push_hit", chk_hit, 1);
    tick(); wr_req = 0;
    chk("t1_idle_empty", empty, 0);
    chk("t1_idle_awvalid", axi.awvalid, 0);
    tick();
    chk("t1_awvalid", axi.awvalid, 1);
    chk("t1_awaddr", axi.awaddr, 32'h1000);
    chk("t1_awlen", axi.awlen, 0);
    chk("t1_awsize", axi.awsize, 2);
    chk("t1_awburst", axi.awburst, 1);
    chk("t1_awid", axi.awid, 1);
    tick();
    chk("t1_wvalid", axi.wvalid, 1);
    chk("t1_wdata", axi.wdata, 32'hdeadbeef);
    chk("t1_wstrb", axi.wstrb, 4'h3);
    chk("t1_wlast", axi.wlast, 1);
    tick();
    chk("t1_bready", axi.bready, 1);
    tick();
    chk("t1_empty", empty, 1);

    // 2: line burst with wready toggling
    axi.wready = 0;
    wr_req = 1; wr_type = 3'b100; wr_addr = 32'h2000; wr_wstrb = 4'h0;
    wr_data = {32'h44, 32'h33, 32'h22, 32'h11};
    tick(); wr_req = 0;
    tick();
    chk("t2_awvalid", axi.awvalid, 1);
    chk("t2_awlen", axi.awlen, 3);
    chk("t2_awsize", axi.awsize, 2);
    tick();
    line2 = {32'h44, 32'h33, 32'h22, 32'h11};
    chk("t2_wstrb", axi.wstrb, 4'hf);
    for (int b = 0; b < 4; b++) begin
      chk("t2_wvalid", axi.wvalid, 1);
      chk("t2_wdata", axi.wdata, line2[32*b +: 32]);
      chk("t2_wlast", axi.wlast, (b == 3) ? 1 : 0);
      tick();
      chk("t2_wdata_hold", axi.wdata, line2[32*b +: 32]);
      axi.wready = 1;
      tick();
      axi.wready = 0;
    end
    chk("t2_bready", axi.bready, 1);
    tick();
    chk("t2_empty", empty, 1);

    // 3: fill with AW stalled, then drain in order with a push on a pop cycle
    axi.awready = 0; axi.wready = 1;
    for (int i = 0; i < 4; i++) begin
      push_word(32'h5000 + 32'(i) * 32'h10, 32'(i));
      #0 chk("t3_fill_rdy", wr_rdy, 1);
      tick();
    end
    wr_req = 0; #1;
    chk("t3_full_rdy", wr_rdy, 0);
    chk("t3_stall_awaddr", axi.awaddr, 32'h5000);
    push_word(32'h9000, 32'h9); #1;
    chk("t3_rejected_hit", chk_hit, 0);
    chk_addr = 32'h9000; #1;
    chk("t3_rejected_hit2", chk_hit, 0);
    wr_req = 0;
    axi.awready = 1;
    wait_aw("t3_e0", 32'h5000);
    wait_aw("t3_e1", 32'h5010);
    wait_b("t3_e1");
    push_word(32'h6000, 32'h60); #1;
    chk("t3_pop_push_rdy", wr_rdy, 1);
    tick(); wr_req = 0;
    wait_aw("t3_e2", 32'h5020);
    wait_aw("t3_e3", 32'h5030);
    wait_aw("t3_e4", 32'h6000);
    wait_empty("t3");
    chk("t3_end_rdy", wr_rdy, 1);

    // 4: hazard lookup
    axi.awready = 0; axi.bvalid = 0;
    wr_req = 1; wr_type = 3'b100; wr_addr = 32'h3000; wr_data = '0;
    chk_addr = 32'h3004; #1;
    chk("t4_same_cycle_hit", chk_hit, 1);
    tick(); wr_req = 0;
    chk_addr = 32'h300c; #1;
    chk("t4_hit_300c", chk_hit, 1);
    chk_addr = 32'h3010; #1;
    chk("t4_miss_3010", chk_hit, 0);
    chk_addr = 32'h2ffc; #1;
    chk("t4_miss_2ffc", chk_hit, 0);
    chk_addr = 32'h300c;
    axi.awready = 1;
    wait_b("t4");
    chk("t4_hit_in_b", chk_hit, 1);
    axi.bvalid = 1;
    tick();
    chk("t4_hit_dropped", chk_hit, 0);
    push_word(32'h4000, 32'h40); chk_addr = 32'h4004; #1;
    chk("t4_push_hit", chk_hit, 1);
    tick(); wr_req = 0;
    wait_empty("t4");

    // 5: sticky error; foreign-ID response is ignored
    axi.bresp = 2'b10;
    push_word(32'ha000, 32'ha); tick(); wr_req = 0;
    wait_b("t5_a");
    chk("t5_err_before", wr_err, 0);
    tick();
    chk("t5_err_set", wr_err, 1);
    axi.bresp = 2'b00;
    push_word(32'ha004, 32'hb); tick(); wr_req = 0;
    axi.bid = 4'd2;
    wait_b("t5_b");
    tick();
    chk("t5_foreign_bid_held", axi.bready, 1);
    axi.bid = 4'd1;
    tick();
    chk("t5_err_sticky", wr_err, 1);
    chk("t5_empty", empty, 1);

    // 6: reset in the middle of a line burst
    wr_req = 1; wr_type = 3'b100; wr_addr = 32'h7000;
    wr_data = {32'h74, 32'h73, 32'h72, 32'h71};
    tick();
    push_word(32'h8000, 32'h80);
    tick(); wr_req = 0;
    wait_aw("t6", 32'h7000);
    tick(); tick();
    chk("t6_beat2_wdata", axi.wdata, 32'h73);
    chk("t6_beat2_wlast", axi.wlast, 0);
    reset = 1;
    tick();
    chk("t6_rst_wvalid", axi.wvalid, 0);
    chk("t6_rst_empty", empty, 1);
    chk("t6_rst_rdy", wr_rdy, 0);
    reset = 0; chk_addr = 32'h8000; #1;
    chk("t6_rdy", wr_rdy, 1);
    chk("t6_empty", empty, 1);
    chk("t6_err_clr", wr_err, 0);
    chk("t6_hit_clr", chk_hit, 0);
    for (int n = 0; n < 8; n++) begin
      chk("t6_no_aw", axi.awvalid, 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
